// File: rtl/smg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// smg_scan_ctrl
//
// Time-multiplexed scan controller for the six-digit seven-segment display
// of the digital watch. One shared segment bus is driven while a single digit
// enable is asserted per scan slot. Each slot begins with a few cycles of
// all-digits-off to suppress ghosting. The BCD display bus is captured once
// per frame so a digit never tears mid-frame. Individual digits can blink
// while the time is being set.
//
// Parameters
//   SCAN_DIV      clk cycles per digit slot (>= 2)
//   BLANK_CYC     leading cycles of each slot with every digit off
//                 (0 <= BLANK_CYC < SCAN_DIV)
//   BLINK_FRAMES  frames per blink half-period (>= 1)
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   disp_in      in   24-bit BCD, [3:0] = digit 0 (seconds units) ..
//                     [23:20] = digit 5 (hours tens); sampled once per frame
//   blink_mask   in   bit i = 1: digit i blinks (sampled live)
//   dp_mask      in   bit i = 1: decimal point of digit i lit (sampled live)
//   seg_out      out  active-low segments, [6:0] = g..a, [7] = dp
//   dig_sel      out  active-low digit enables, bit i = digit i
//   frame_start  out  one-cycle pulse on the first cycle of each digit-0 slot
// ---------------------------------------------------------------------------
module smg_scan_ctrl #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 500,
    parameter int BLINK_FRAMES = 83
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] disp_in,
    input  logic [5:0]  blink_mask,
    input  logic [5:0]  dp_mask,
    output logic [7:0]  seg_out,
    output logic [5:0]  dig_sel,
    output logic        frame_start
);

    // Counter widths; the frame counter keeps at least one bit so that a
    // blink half-period of a single frame still elaborates cleanly.
    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYC);
    localparam logic [FW-1:0] FC_LAST = FW'(BLINK_FRAMES - 1);

    localparam logic [2:0]    IDX_LAST = 3'd5;

    // Scan state
    logic [PW-1:0] p;
    logic [2:0]    idx;
    logic [23:0]   snap;
    logic [FW-1:0] fc;
    logic          bp;

    // Derived control
    logic          slot_end;
    logic          frame_end;
    logic [5:0]    dig_onehot;
    logic [3:0]    nibble;
    logic [6:0]    seg_digit;
    logic          in_blank;
    logic          blink_off;
    logic          dp_on;

    // Next values of the registered outputs
    logic [7:0]    seg_nxt;
    logic [5:0]    dig_nxt;
    logic          fs_nxt;

    assign slot_end  = (p == P_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // Prescaler, digit index, snapshot and blink phase. The snapshot and the
    // blink toggle both land on the frame-wrap cycle, so a new frame starts
    // with a consistent digit image and blink phase from its first slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p    <= '0;
            idx  <= '0;
            snap <= '0;
            fc   <= '0;
            bp   <= 1'b0;
        end else begin
            if (slot_end) begin
                p <= '0;
                if (idx == IDX_LAST) begin
                    idx <= '0;
                end else begin
                    idx <= idx + 3'd1;
                end
            end else begin
                p <= p + PW'(1);
            end

            if (frame_end) begin
                snap <= disp_in;
                if (fc == FC_LAST) begin
                    fc <= '0;
                    bp <= ~bp;
                end else begin
                    fc <= fc + FW'(1);
                end
            end
        end
    end

    // Pick the snapshot nibble for the digit currently being scanned.
    // Index values beyond 5 never occur; they fall back to digit 0.
    always_comb begin
        nibble = snap[3:0];
        case (idx)
            3'd0:    nibble = snap[3:0];
            3'd1:    nibble = snap[7:4];
            3'd2:    nibble = snap[11:8];
            3'd3:    nibble = snap[15:12];
            3'd4:    nibble = snap[19:16];
            3'd5:    nibble = snap[23:20];
            default: nibble = snap[3:0];
        endcase
    end

    // BCD to active-low g..a. Non-decimal nibbles show a dark digit while
    // the digit enable stays asserted, so the scan timing is unchanged.
    always_comb begin
        seg_digit = 7'h7F;
        case (nibble)
            4'd0:    seg_digit = 7'h40;
            4'd1:    seg_digit = 7'h79;
            4'd2:    seg_digit = 7'h24;
            4'd3:    seg_digit = 7'h30;
            4'd4:    seg_digit = 7'h19;
            4'd5:    seg_digit = 7'h12;
            4'd6:    seg_digit = 7'h02;
            4'd7:    seg_digit = 7'h78;
            4'd8:    seg_digit = 7'h00;
            4'd9:    seg_digit = 7'h10;
            default: seg_digit = 7'h7F;
        endcase
    end

    // Output selection. The digit is switched off during the anti-ghosting
    // window at the head of each slot and while it is in the dark half of a
    // blink. Both masks are applied live rather than from the snapshot so
    // the time-set UI responds within a cycle.
    always_comb begin
        dig_onehot = 6'b000001 << idx;
        in_blank   = (p < P_BLANK);
        blink_off  = bp && ((blink_mask & dig_onehot) != 6'b0);
        dp_on      = ((dp_mask & dig_onehot) != 6'b0);
        fs_nxt     = (p == '0) && (idx == 3'd0);

        seg_nxt = 8'hFF;
        dig_nxt = 6'h3F;
        if (!in_blank && !blink_off) begin
            seg_nxt = {~dp_on, seg_digit};
            dig_nxt = ~dig_onehot;
        end
    end

    // Output register: every output shows the previous cycle's scan state,
    // and reset turns the display fully off without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out     <= 8'hFF;
            dig_sel     <= 6'h3F;
            frame_start <= 1'b0;
        end else begin
            seg_out     <= seg_nxt;
            dig_sel     <= dig_nxt;
            frame_start <= fs_nxt;
        end
    end

endmodule

// File: tb/tb_smg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_smg_scan_ctrl
//
// Directed bench for smg_scan_ctrl with SCAN_DIV=4, BLANK_CYC=1 and
// BLINK_FRAMES=2, so one frame is 24 cycles. Outputs are sampled on the
// falling clock edge. Expected segment images per frame are written out by
// hand as packed byte tables, digit 0 in the low byte.
// ---------------------------------------------------------------------------
module tb_smg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [23:0] disp_in = 24'h0;
    logic [5:0]  blink_mask = 6'h0;
    logic [5:0]  dp_mask = 6'h0;
    logic [7:0]  seg_out;
    logic [5:0]  dig_sel;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    // Hand-computed frame images {d5, d4, d3, d2, d1, d0}
    localparam logic [47:0] IMG_ZERO   = {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
    localparam logic [47:0] IMG_123456 = {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82};
    localparam logic [47:0] IMG_654321 = {8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    localparam logic [47:0] IMG_INV_DP = {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h7F};
    localparam logic [47:0] DIG_TAB    = {8'h1F, 8'h2F, 8'h37, 8'h3B, 8'h3D, 8'h3E};
    localparam int          NO_CHANGE  = 6;

    always #5 clk = ~clk;

    smg_scan_ctrl #(
        .SCAN_DIV    (4),
        .BLANK_CYC   (1),
        .BLINK_FRAMES(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .disp_in    (disp_in),
        .blink_mask (blink_mask),
        .dp_mask    (dp_mask),
        .seg_out    (seg_out),
        .dig_sel    (dig_sel),
        .frame_start(frame_start)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [23:0] d, input logic [5:0] bm,
                                 input logic [5:0] dm);
        disp_in    = d;
        blink_mask = bm;
        dp_mask    = dm;
    endtask

    // Check one full 24-cycle frame. off[i] marks digit i as blinked dark.
    // disp_in may be changed at the start of slot chg_slot to probe tearing.
    task automatic checkFrame(input string tag, input logic [47:0] img,
                              input logic [5:0] off, input int chg_slot,
                              input logic [23:0] chg_val);
        logic [47:0] segs;
        logic [47:0] digs;
        logic [7:0]  exp_seg;
        logic [5:0]  exp_dig;
        logic        exp_fs;
        segs = img;
        digs = DIG_TAB;
        for (int s = 0; s < 6; s++) begin
            for (int c = 0; c < 4; c++) begin
                if (s == chg_slot && c == 0) disp_in = chg_val;
                @(negedge clk);
                if (c == 0 || off[s]) begin
                    exp_seg = 8'hFF;
                    exp_dig = 6'h3F;
                end else begin
                    exp_seg = segs[8*s +: 8];
                    exp_dig = digs[8*s +: 6];
                end
                exp_fs = (s == 0 && c == 0);
                checkOutput($sformatf("%s_d%0d_c%0d_seg", tag, s, c), 32'(seg_out), 32'(exp_seg));
                checkOutput($sformatf("%s_d%0d_c%0d_dig", tag, s, c), 32'(dig_sel), 32'(exp_dig));
                checkOutput($sformatf("%s_d%0d_c%0d_fs", tag, s, c), 32'(frame_start), 32'(exp_fs));
            end
        end
    endtask

    initial begin
        applyStimulus(24'h0, 6'h0, 6'h0);
        #1 rst_n = 1'b0;

        // Reset held for five cycles: display fully off, no frame pulse
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput($sformatf("rst_hold%0d_seg", i), 32'(seg_out), 32'h0FF);
            checkOutput($sformatf("rst_hold%0d_dig", i), 32'(dig_sel), 32'h03F);
            checkOutput($sformatf("rst_hold%0d_fs", i), 32'(frame_start), 32'h0);
        end
        applyStimulus(24'h123456, 6'h0, 6'h0);
        rst_n = 1'b1;

        // First frame shows the zero snapshot, then the captured value
        checkFrame("f0_zero", IMG_ZERO, 6'h00, NO_CHANGE, 24'h0);
        checkFrame("f1_scan", IMG_123456, 6'h00, NO_CHANGE, 24'h0);

        // Mid-frame change stays invisible until the next frame
        checkFrame("f2_tear", IMG_123456, 6'h00, 2, 24'h654321);
        checkFrame("f3_new", IMG_654321, 6'h00, 1, 24'h00000A);

        // Non-decimal nibble with decimal point on digit 0
        applyStimulus(24'h00000A, 6'h00, 6'h01);
        checkFrame("f4_inv_dp", IMG_INV_DP, 6'h00, 3, 24'h123456);

        // Blink on digits 0 and 1: phase is dark in frames 6,7 and 10,11
        applyStimulus(24'h123456, 6'h03, 6'h00);
        checkFrame("f5_blink_on", IMG_123456, 6'h00, NO_CHANGE, 24'h0);
        checkFrame("f6_blink_dark", IMG_123456, 6'h03, NO_CHANGE, 24'h0);
        checkFrame("f7_blink_dark", IMG_123456, 6'h03, NO_CHANGE, 24'h0);
        checkFrame("f8_blink_on", IMG_123456, 6'h00, NO_CHANGE, 24'h0);
        checkFrame("f9_blink_on", IMG_123456, 6'h00, NO_CHANGE, 24'h0);
        checkFrame("f10_blink_dark", IMG_123456, 6'h03, NO_CHANGE, 24'h0);

        // Run into the digit-3 slot of frame 11, then pulse reset
        for (int i = 0; i < 14; i++) @(negedge clk);
        checkOutput("pre_rst_seg", 32'(seg_out), 32'h0B0);
        checkOutput("pre_rst_dig", 32'(dig_sel), 32'h037);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_seg", 32'(seg_out), 32'h0FF);
        checkOutput("rst_async_dig", 32'(dig_sel), 32'h03F);
        checkOutput("rst_async_fs", 32'(frame_start), 32'h0);
        @(negedge clk);
        checkOutput("rst_low_seg", 32'(seg_out), 32'h0FF);
        checkOutput("rst_low_dig", 32'(dig_sel), 32'h03F);
        checkOutput("rst_low_fs", 32'(frame_start), 32'h0);
        rst_n = 1'b1;

        // Restarted scan: zero snapshot, blink phase cleared
        checkFrame("r0_zero", IMG_ZERO, 6'h00, NO_CHANGE, 24'h0);
        checkFrame("r1_scan", IMG_123456, 6'h00, NO_CHANGE, 24'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
